// File: rtl/axis_tx_pkg.sv
// Shared definitions for the AXI-Stream operand transmitter.
// Holds the FSM state encoding, the skid FIFO geometry and the read-credit
// helper used by the top level to decide whether another buffer read may be
// issued without overflowing the FIFO.
package axis_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tx_state_t;

  localparam int TX_FIFO_DEPTH = 2;
  localparam int TX_CNT_WIDTH  = $clog2(TX_FIFO_DEPTH + 1);

  // True when the entries already held plus the read in flight, minus the
  // entry leaving this cycle, still leave room for one more read.
  function automatic logic tx_credit_ok(
    input logic [TX_CNT_WIDTH-1:0] count,
    input logic                    inflight,
    input logic                    pop
  );
    logic [TX_CNT_WIDTH:0] occ;
    logic [TX_CNT_WIDTH:0] lim;
    occ = {1'b0, count} + {{TX_CNT_WIDTH{1'b0}}, inflight};
    lim = (TX_CNT_WIDTH+1)'(TX_FIFO_DEPTH) + {{TX_CNT_WIDTH{1'b0}}, pop};
    return (occ < lim);
  endfunction

endpackage

// File: rtl/axis_tx_skid_fifo.sv
// Two-entry register FIFO that absorbs the one-cycle buffer read latency.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   push, din  : write strobe and entry {last tag, data}
//   pop        : remove the head entry (ignored when empty)
//   dout       : head entry, driven straight from a register
//   count      : number of valid entries (0..2)
//   empty      : no valid entry
// The head always sits in head_r so the output never passes through a mux;
// a pop shifts the tail entry forward.
module axis_tx_skid_fifo
  import axis_tx_pkg::*;
#(
  parameter int WIDTH = 129
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [TX_CNT_WIDTH-1:0] count,
  output logic                    empty
);

  localparam logic [TX_CNT_WIDTH-1:0] CNT_ZERO = {TX_CNT_WIDTH{1'b0}};
  localparam logic [TX_CNT_WIDTH-1:0] CNT_ONE  = TX_CNT_WIDTH'(1'b1);
  localparam logic [TX_CNT_WIDTH-1:0] CNT_FULL = TX_CNT_WIDTH'(TX_FIFO_DEPTH);

  logic [WIDTH-1:0]        head_r;
  logic [WIDTH-1:0]        tail_r;
  logic [TX_CNT_WIDTH-1:0] count_r;
  logic                    do_pop_s;
  logic                    do_push_s;

  // Qualify the strobes: no pop from empty, no push into a full FIFO unless
  // an entry leaves in the same cycle.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (count_r != CNT_ZERO) begin
      do_pop_s = pop;
    end else begin
      do_pop_s = 1'b0;
    end
    if ((count_r != CNT_FULL) || do_pop_s) begin
      do_push_s = push;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Entry storage and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {WIDTH{1'b0}};
      tail_r  <= {WIDTH{1'b0}};
      count_r <= CNT_ZERO;
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10: begin
          if (count_r == CNT_ZERO) begin
            head_r <= din;
          end else begin
            tail_r <= din;
          end
          count_r <= count_r + CNT_ONE;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - CNT_ONE;
        end
        2'b11: begin
          if (count_r == CNT_ONE) begin
            head_r <= din;
          end else begin
            head_r <= tail_r;
            tail_r <= din;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign dout  = head_r;
  assign count = count_r;
  assign empty = (count_r == CNT_ZERO);

endmodule

// File: rtl/axis_matrix_stream_tx.sv
// AXI-Stream master that streams operand beats from a synchronous-read
// buffer into the systolic-array wrapper's S00 port.
// Ports:
//   m00_axis_aclk / m00_axis_aresetn : clock, asynchronous active-low reset
//   i_start, i_base_addr, i_len, i_row_mask : transfer request (IDLE only)
//   o_busy, o_done : status; o_done pulses once per completed transfer
//   o_rd_en, o_rd_addr, i_rd_data : buffer read port, data one cycle later
//   m00_axis_* : AXI-Stream master; tstrb carries the row-valid mask
// Each read carries a "last" tag that travels with the data through the
// skid FIFO, so tlast comes straight from the FIFO head.
module axis_matrix_stream_tx
  import axis_tx_pkg::*;
#(
  parameter int C_M00_AXIS_TDATA_WIDTH = 128,
  parameter int C_M00_STRB_WIDTH       = C_M00_AXIS_TDATA_WIDTH/8,
  parameter int NUM_ROW                = 8,
  parameter int ADDR_WIDTH             = 10,
  parameter int LEN_WIDTH              = 16
) (
  input  logic                              m00_axis_aclk,
  input  logic                              m00_axis_aresetn,
  input  logic                              i_start,
  input  logic [ADDR_WIDTH-1:0]             i_base_addr,
  input  logic [LEN_WIDTH-1:0]              i_len,
  input  logic [NUM_ROW-1:0]                i_row_mask,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_rd_en,
  output logic [ADDR_WIDTH-1:0]             o_rd_addr,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] i_rd_data,
  output logic                              m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic [C_M00_STRB_WIDTH-1:0]       m00_axis_tstrb,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready
);

  localparam int                   DW       = C_M00_AXIS_TDATA_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1'b1);

  tx_state_t               state_r;
  tx_state_t               state_s;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [LEN_WIDTH-1:0]    issue_cnt_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [NUM_ROW-1:0]      row_mask_r;
  logic                    inflight_r;
  logic                    inflight_last_r;
  logic                    done_r;

  logic                    start_ok_s;
  logic                    rd_en_s;
  logic                    last_issue_s;
  logic                    pop_s;
  logic                    tvalid_s;
  logic                    tlast_s;
  logic [C_M00_STRB_WIDTH-1:0] tstrb_s;

  logic [DW:0]             fifo_din_s;
  logic [DW:0]             fifo_head_s;
  logic [TX_CNT_WIDTH-1:0] fifo_count_s;
  logic                    fifo_empty_s;

  // Handshake, read-issue and start qualification for the current cycle.
  always_comb begin
    start_ok_s   = (state_r == IDLE) && i_start;
    tvalid_s     = !fifo_empty_s;
    tlast_s      = fifo_head_s[DW] && tvalid_s;
    pop_s        = tvalid_s && m00_axis_tready;
    last_issue_s = (issue_cnt_r == (len_r - LEN_ONE));
    if ((state_r == RUN) && (issue_cnt_r < len_r)) begin
      rd_en_s = tx_credit_ok(fifo_count_s, inflight_r, pop_s);
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_start && (i_len != LEN_ZERO)) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (rd_en_s && last_issue_s) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (pop_s && tlast_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Transfer parameters, issue counter, read-latency tracking and done pulse.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      len_r           <= LEN_ZERO;
      issue_cnt_r     <= LEN_ZERO;
      base_r          <= {ADDR_WIDTH{1'b0}};
      row_mask_r      <= {NUM_ROW{1'b0}};
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      if (start_ok_s && (i_len != LEN_ZERO)) begin
        len_r       <= i_len;
        base_r      <= i_base_addr;
        row_mask_r  <= i_row_mask;
        issue_cnt_r <= LEN_ZERO;
      end else if (rd_en_s) begin
        issue_cnt_r <= issue_cnt_r + LEN_ONE;
      end else begin
        issue_cnt_r <= issue_cnt_r;
      end
      inflight_r      <= rd_en_s;
      inflight_last_r <= rd_en_s && last_issue_s;
      // A zero-length start completes immediately; otherwise completion is
      // the accepted tlast beat.
      done_r <= (start_ok_s && (i_len == LEN_ZERO)) ||
                ((state_r == DRAIN) && pop_s && tlast_s);
    end
  end

  // Row mask occupies the low tstrb bits; upper bits are always zero.
  always_comb begin
    tstrb_s              = {C_M00_STRB_WIDTH{1'b0}};
    tstrb_s[NUM_ROW-1:0] = row_mask_r;
  end

  assign fifo_din_s = {inflight_last_r, i_rd_data};

  axis_tx_skid_fifo #(
    .WIDTH (DW + 1)
  ) u_fifo (
    .clk   (m00_axis_aclk),
    .rst_n (m00_axis_aresetn),
    .push  (inflight_r),
    .pop   (pop_s),
    .din   (fifo_din_s),
    .dout  (fifo_head_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  // Address wraps modulo the buffer size by truncation.
  assign o_rd_addr       = base_r + issue_cnt_r[ADDR_WIDTH-1:0];
  assign o_rd_en         = rd_en_s;
  assign o_busy          = (state_r != IDLE);
  assign o_done          = done_r;
  assign m00_axis_tvalid = tvalid_s;
  assign m00_axis_tdata  = fifo_head_s[DW-1:0];
  assign m00_axis_tlast  = tlast_s;
  assign m00_axis_tstrb  = tstrb_s;

endmodule

// File: doc/axis_matrix_stream_tx.md
# axis_matrix_stream_tx

AXI-Stream master that streams input operand beats from a local synchronous-read buffer into the slave port (S00) of the systolic-array AXI wrapper. It is the transmitter counterpart of that wrapper's S00 receiver. Software or a controller FSM issues a start with a base address, beat count and row mask. The block then reads the buffer, absorbs the 1-cycle read latency in a 2-entry skid FIFO, and emits full-throughput beats under tready back-pressure, with tstrb carrying the per-row valid mask and tlast on the final beat.

## Interface
- C_M00_AXIS_TDATA_WIDTH, 128, stream data width (equal to the wrapper's C_S00_AXIS_TDATA_WIDTH)
- C_M00_STRB_WIDTH, C_M00_AXIS_TDATA_WIDTH/8, tstrb width
- NUM_ROW, 8, number of array rows; tstrb[NUM_ROW-1:0] is the row-valid mask (NUM_ROW ≤ C_M00_STRB_WIDTH)
- ADDR_WIDTH, 10, buffer address width
- LEN_WIDTH, 16, beat-count width
- m00_axis_aclk in 1: the single clock
- m00_axis_aresetn in 1: asynchronous, active-low reset
- i_start in 1: one-cycle start request, honoured only in IDLE
- i_base_addr in ADDR_WIDTH: first buffer address, latched on an accepted start
- i_len in LEN_WIDTH: beat count, latched on an accepted start
- i_row_mask in NUM_ROW: row-valid mask, latched on an accepted start
- o_busy out 1: high whenever state ≠ IDLE
- o_done out 1: one-cycle pulse when a transfer completes
- o_rd_en out 1: buffer read strobe
- o_rd_addr out ADDR_WIDTH: buffer read address
- i_rd_data in C_M00_AXIS_TDATA_WIDTH: buffer data, valid the cycle after o_rd_en
- m00_axis_tvalid out 1
- m00_axis_tdata out C_M00_AXIS_TDATA_WIDTH
- m00_axis_tstrb out C_M00_STRB_WIDTH
- m00_axis_tlast out 1
- m00_axis_tready in 1

## Operation
- **Reset values:** tvalid, tlast, o_busy, o_done and o_rd_en are 0; tdata, tstrb and o_rd_addr are 0; state is IDLE; FIFO is empty; counters are 0.
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE, i_start=1, i_len>0: latch the parameters, clear issue_cnt, go to RUN.
  - IDLE, i_start=1, i_len=0: pulse o_done the next cycle and stay in IDLE. No beats are sent.
  - RUN: issue reads. When issue_cnt reaches len on a read, go to DRAIN.
  - DRAIN: wait for the handshake (tvalid & tready) on the tlast beat, then go to IDLE with o_done=1 for one cycle.
  - i_start is ignored while busy.
- **Read issue:**
  - o_rd_en = RUN & (issue_cnt < len) & (fifo_count + inflight − pop < 2).
  - pop = tvalid & tready, evaluated in the same cycle.
  - inflight = o_rd_en registered one cycle.
- **Addressing:** o_rd_addr = base + issue_cnt, modulo 2^ADDR_WIDTH (wraps silently).
- **Tag:** each read carries last = (issue_cnt == len−1). The tag travels with the data into the FIFO.
- **FIFO push:** the FIFO is pushed when inflight=1, with {last tag, i_rd_data}.
- **Output fields:**
  - tdata = FIFO head.
  - tstrb = {zeros, row_mask}, constant for the whole transfer.
  - tlast = head tag.
  - tvalid = FIFO non-empty.
- **AXIS rules:** once tvalid is high, tvalid, tdata, tstrb and tlast stay stable until tready. tvalid never depends combinationally on tready.
- **Mid-operation reset:** asynchronous; the outputs drop to their reset values immediately. The partial transfer is abandoned and there is no o_done.

## Timing
- Start accepted in cycle n:
  - cycle n+1: RUN, first o_rd_en.
  - cycle n+2: data is pushed.
  - cycle n+3: first tvalid.
- With tready held at 1: one beat per cycle, the last beat in cycle n+2+len, o_done in cycle n+3+len.
- With tready=0: at most 2 beats are buffered and reads stall. Throughput resumes the cycle tready returns; no beat is lost or duplicated.
- Push and pop in the same cycle, FIFO full: allowed. The read credit already accounts for it.
- A new start is accepted in the cycle after o_done (back-to-back transfers).

## Structure
- Shared package/header axis_tx_pkg holds:
  - the state encodings IDLE=2'd0, RUN=2'd1, DRAIN=2'd2;
  - the FIFO depth constant TX_FIFO_DEPTH=2.
- Sub-module axis_tx_skid_fifo:
  - 2-entry register FIFO, width C_M00_AXIS_TDATA_WIDTH+1;
  - ports: push, pop, din, dout, count, empty;
  - asynchronous active-low reset.
- The top level holds the FSM, the counters and the tstrb formation.

## Test plan
- **Single beat:** len=1, base=5, mask=8'hFF, tready=1 → one o_rd_en at addr 5 in n+1; tvalid & tlast in n+3 with tdata=mem[5] and tstrb=16'h00FF; o_done in n+4.
- **Streaming:** len=16, base=0, tready=1 → 16 consecutive beats mem[0..15], tlast only on beat 16, no bubbles.
- **Back-pressure:** len=8, tready toggled randomly, including 10 cycles low → all 8 beats in order; tdata/tlast stable while stalled; the FIFO count never exceeds 2.
- **Wrap and mask:** base=1022, len=4, ADDR_WIDTH=10, mask=8'h0F → addresses 1022, 1023, 0, 1; tstrb=16'h000F on every beat.
- **Boundaries:** i_len=0 → o_done one cycle later and no tvalid. A start while busy is ignored. Reset asserted mid-transfer (after 3 beats) → tvalid=0 immediately; a fresh start afterwards streams correctly from its base.
